// File: rtl/spi_ram_arbiter_pkg.sv
// Shared types and constants for the SPI/host RAM arbiter.
// No logic; pure declarations.
// Not applicable (no flow control in a package).
package spi_ram_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    // SPI frame opcodes, rx_data[9:8]
    localparam logic [1:0] OP_WADDR = 2'b00;
    localparam logic [1:0] OP_WDATA = 2'b01;
    localparam logic [1:0] OP_RADDR = 2'b10;
    localparam logic [1:0] OP_RDATA = 2'b11;

    // Requester identity; the value doubles as the gnt/req bit index
    typedef enum logic {
        REQ_SPI  = 1'b0,
        REQ_HOST = 1'b1
    } req_e;

    // One RAM access as seen on the ram_* port
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } ram_op_t;

endpackage

// File: rtl/spi_ram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter (bit 0 = SPI, bit 1 = host) with a registered last-grant pointer.
// Grant is combinational from req in the same cycle; pointer updates at the grant edge.
// A lone requester always wins; on contention the one not granted last wins.
module rr_arb2
    import spi_ram_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_e last;

    // Grant decode: lone requester wins, contention goes to the side not served last
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == REQ_HOST) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Remember who was served; reset to HOST so SPI wins the first contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= REQ_HOST;
        end else if (gnt[0]) begin
            last <= REQ_SPI;
        end else if (gnt[1]) begin
            last <= REQ_HOST;
        end
    end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares one single-port RAM between decoded SPI frames and a host port, round-robin.
// RAM access in the grant cycle; read data strobes out 2 cycles after issue.
// SPI cannot be stalled (one pending slot, overflow drops + sticky flag); host holds req until gnt.
module spi_ram_arbiter
    import spi_ram_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_W,
    parameter int DATA_SIZE = DATA_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9:0]           rx_data,
    input  logic                 rx_valid,
    output logic [DATA_SIZE-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [DATA_SIZE-1:0] host_wdata,
    output logic                 host_gnt,
    output logic                 host_rvalid,
    output logic [DATA_SIZE-1:0] host_rdata,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [DATA_SIZE-1:0] ram_wdata,
    input  logic [DATA_SIZE-1:0] ram_rdata,
    output logic                 spi_ovf
);

    logic [1:0]        opcode;
    logic [ADDR_W-1:0] payload;
    logic              rx_is_access;

    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr;

    logic              pend_vld;
    ram_op_t           pend_op;
    ram_op_t           new_op;
    ram_op_t           iss_op;

    logic [1:0]        arb_req;
    logic [1:0]        arb_gnt;
    logic              spi_gnt;

    logic              rd_vld;
    req_e              rd_tag;

    assign opcode       = rx_data[9:8];
    assign payload      = rx_data[7:0];
    // Opcodes 01 and 11 are the ones that touch the RAM
    assign rx_is_access = rx_valid && opcode[0];

    assign arb_req  = {host_req, pend_vld};
    assign spi_gnt  = arb_gnt[0];
    assign host_gnt = arb_gnt[1];

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (arb_req),
        .gnt   (arb_gnt)
    );

    // Build the SPI op at capture time so later address frames cannot alter it
    always_comb begin
        new_op       = '0;
        new_op.we    = (opcode == OP_WDATA);
        new_op.addr  = (opcode == OP_WDATA) ? waddr : raddr;
        new_op.wdata = (opcode == OP_WDATA) ? payload : '0;
    end

    // Drive the RAM port from whichever requester won this cycle; idle port is all zero
    always_comb begin
        iss_op = '0;
        ram_en = 1'b0;
        if (spi_gnt) begin
            iss_op = pend_op;
            ram_en = 1'b1;
        end else if (host_gnt) begin
            iss_op.we    = host_we;
            iss_op.addr  = ADDR_W'(host_addr);
            iss_op.wdata = DATA_W'(host_wdata);
            ram_en       = 1'b1;
        end
        ram_we    = iss_op.we;
        ram_addr  = ADDR_SIZE'(iss_op.addr);
        ram_wdata = DATA_SIZE'(iss_op.wdata);
    end

    // Address registers set by the 00/10 frames; these are never blocked by overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr <= '0;
            raddr <= '0;
        end else if (rx_valid) begin
            if (opcode == OP_WADDR) waddr <= payload;
            if (opcode == OP_RADDR) raddr <= payload;
        end
    end

    // One-entry SPI pending slot: a grant frees it and a same-cycle frame refills it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld <= 1'b0;
            pend_op  <= '0;
        end else if (rx_is_access && (!pend_vld || spi_gnt)) begin
            pend_vld <= 1'b1;
            pend_op  <= new_op;
        end else if (spi_gnt) begin
            pend_vld <= 1'b0;
        end
    end

    // Sticky overflow: an access frame arrived while the slot was still occupied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_ovf <= 1'b0;
        end else if (rx_is_access && pend_vld && !spi_gnt) begin
            spi_ovf <= 1'b1;
        end
    end

    // Tag each issued read with its destination so returns pipeline one per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld <= 1'b0;
            rd_tag <= REQ_SPI;
        end else begin
            rd_vld <= ram_en && !ram_we;
            rd_tag <= host_gnt ? REQ_HOST : REQ_SPI;
        end
    end

    // Register returning RAM data toward its requester; data holds between strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid    <= 1'b0;
            tx_data     <= '0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            tx_valid    <= rd_vld && (rd_tag == REQ_SPI);
            host_rvalid <= rd_vld && (rd_tag == REQ_HOST);
            if (rd_vld && (rd_tag == REQ_SPI))  tx_data    <= ram_rdata;
            if (rd_vld && (rd_tag == REQ_HOST)) host_rdata <= ram_rdata;
        end
    end

endmodule

// File: doc/spi_ram_arbiter.md
# spi_ram_arbiter

Shares the single-port RAM between the SPI slave command stream and a local host port. Decodes the 10-bit SPI frames (`rx_data`/`rx_valid`) into RAM writes and reads, and arbitrates them round-robin against host requests. It issues at most one RAM access per cycle and routes read data back to the SPI slave (`tx_data`/`tx_valid`) or to the host.

## Interface
- `ADDR_SIZE`, 8: RAM address width; the SPI payload is `rx_data[7:0]`.
- `DATA_SIZE`, 8: RAM word width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_data` in 10: SPI frame; [9:8] opcode, [7:0] payload.
- `rx_valid` in 1: one-cycle frame strobe; cannot be stalled.
- `tx_data` out 8: read data to the SPI slave.
- `tx_valid` out 1: one-cycle strobe qualifying `tx_data`.
- `host_req` in 1: host access request; held until granted.
- `host_we` in 1: 1 = write, 0 = read.
- `host_addr` in ADDR_SIZE: host address.
- `host_wdata` in DATA_SIZE: host write data.
- `host_gnt` out 1: combinational, one-cycle pulse; the request issues this cycle.
- `host_rvalid` out 1: one-cycle strobe qualifying `host_rdata`.
- `host_rdata` out DATA_SIZE: host read data.
- `ram_en`, `ram_we` out 1: RAM access strobe and write enable.
- `ram_addr` out ADDR_SIZE, `ram_wdata` out DATA_SIZE: RAM address and write data.
- `ram_rdata` in DATA_SIZE: valid the cycle after a read with `ram_en`=1.
- `spi_ovf` out 1: sticky flag; an SPI frame was dropped.

## Operation
- SPI opcodes:
  - 00: `waddr <= payload`. No RAM access.
  - 01: write `payload` to `waddr`.
  - 10: `raddr <= payload`. No RAM access.
  - 11: read `raddr`; the payload is ignored.
- Opcodes 01 and 11 load a one-entry SPI pending register `{valid, we, addr, wdata}`. The address is resolved at capture, so a later 00 or 10 does not change a queued op.
- Arbitration: a 2-way round-robin between pending-SPI and `host_req`, over one pointer `last`.
  - A lone requester is granted immediately.
  - On contention, grant the requester not granted last.
  - `last` updates on every grant; reset value = HOST, so SPI wins the first contention.
- The granted op drives `ram_*` combinationally in the grant cycle. Otherwise `ram_en`=0 and the other `ram_*` outputs are 0.
- A granted SPI op clears pending in that cycle. A new `rx_valid` in that same cycle refills pending with no loss.
- Overflow: `rx_valid` for opcode 01/11 while pending is valid and not granted this cycle drops the new frame and sets `spi_ovf`. `spi_ovf` clears only on reset. An opcode 00/10 frame in that cycle still updates its register.
- Read return: a 1-bit destination tag is registered at issue. In cycle N+1, `ram_rdata` is registered into `tx_data`/`tx_valid` or `host_rdata`/`host_rvalid`; the strobe is visible in N+2.
- Reset: all outputs, `waddr`, `raddr`, pending, `last`=HOST, tag and `spi_ovf` go to 0. An in-flight read is discarded, with no strobe.

## Timing
- Read issue to read strobe: 2 cycles. Uncontended SPI: `rx_valid` at cycle N, `ram_en` at N+1, `tx_valid` at N+3.
- Write: RAM is written at the grant edge; no completion strobe.
- Throughput: one access per cycle; back-to-back reads pipeline, one tag per cycle.
- Worst-case SPI wait is one cycle. With SPI frames at least 11 cycles apart, `spi_ovf` never sets in legal traffic.
- `tx_data` and `host_rdata` hold their last value between strobes.

## Structure
- Package `spi_ram_pkg`:
  - opcode constants `OP_WADDR`=2'b00, `OP_WDATA`=2'b01, `OP_RADDR`=2'b10, `OP_RDATA`=2'b11;
  - requester enum `{REQ_SPI, REQ_HOST}`;
  - the `ram_op_t` struct `{we, addr, wdata}`.
- Sub-module `rr_arb2`: 2-input round-robin with a registered `last` pointer, inputs `req[1:0]`, output one-hot `gnt[1:0]`. Everything else lives in the top module.

## Test plan
- SPI write then read: frames 0x005, 0x1A5, 0x205, 0x300 → RAM[5]=0xA5; `tx_data`=0xA5 with `tx_valid` 2 cycles after the read's `ram_en`; `host_rvalid` stays 0.
- Contention: pending SPI write addr 3 plus a host read of addr 3 in the same cycle after reset → SPI granted first, host one cycle later; `host_rdata`=new data.
- Round-robin: hold `host_req` continuously while SPI issues 0x1xx frames every 11 cycles → grants alternate on every contention; no `spi_ovf`.
- Overflow: force contention by holding `host_req` with `last`=SPI, then send two 0x1xx frames on consecutive cycles → second frame dropped, `spi_ovf`=1 until reset.
- Reset mid-read: assert `rst_n`=0 the cycle after a read's `ram_en` → no `tx_valid`/`host_rvalid`; all outputs 0; the first post-reset contention grants SPI.
- Host pipelining: three host reads of addrs 1, 2, 3 on back-to-back cycles → `host_rvalid` on three consecutive cycles with the data in order.
